// File: rtl/serial_crc_ccitt_ctrl.sv
// serial_crc_ccitt_ctrl
//   Byte-stream sequencer for an external bit-serial CRC-CCITT engine. Bytes arrive over a
//   valid/ready stream. The engine is initialised at frame start, and each byte is shifted in
//   MSB-first, one bit per clock. At frame end the final CRC and byte count are returned over a
//   result valid/ready handshake.
//
//   Optional feature macro: CRC_CTRL_XOROUT_EN
//     defined   : res_crc = crc_in ^ XOROUT, captured on entry to the result state
//     undefined : res_crc = crc_in unmodified
//
// Parameters
//   LEN_W    width of the frame byte counter (saturates at 2**LEN_W-1)
//   XOROUT   final XOR mask (only applied with CRC_CTRL_XOROUT_EN)
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  input byte stream
//   crc_init/crc_en/crc_m        engine controls (load init, shift enable, message bit)
//   crc_in                       engine registered crc_out
//   res_valid/res_ready          result handshake
//   res_crc/res_len              final CRC and frame byte count
module serial_crc_ccitt_ctrl #(
    parameter int unsigned LEN_W  = 16,
    parameter logic [15:0] XOROUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             crc_init,
    output logic             crc_en,
    output logic             crc_m,
    input  logic [15:0]      crc_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_crc,
    output logic [LEN_W-1:0] res_len
);

`ifdef CRC_CTRL_XOROUT_EN
    localparam logic [15:0] XorMask = XOROUT;
`else
    // Mask forced to zero: the CRC passes through unmodified.
    localparam logic [15:0] XorMask = XOROUT & 16'h0000;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShift,
        StWait,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              last_q, last_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       res_crc_q, res_crc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shreg_q   <= 8'h00;
            last_q    <= 1'b0;
            bitcnt_q  <= 3'd0;
            len_q     <= '0;
            res_crc_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            bitcnt_q  <= bitcnt_d;
            len_q     <= len_d;
            res_crc_q <= res_crc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        bitcnt_d  = bitcnt_q;
        len_d     = len_q;
        res_crc_d = res_crc_q;
        s_ready   = 1'b0;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        crc_m     = 1'b0;
        res_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    shreg_d = s_data;
                    last_d  = s_last;
                    len_d   = LEN_W'(1);
                    state_d = StInit;
                end
            end
            StInit: begin
                crc_init = 1'b1;
                bitcnt_d = 3'd0;
                state_d  = StShift;
            end
            StShift: begin
                crc_en   = 1'b1;
                crc_m    = shreg_q[7];
                shreg_d  = {shreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = last_q ? StFlush : StWait;
                end
            end
            StWait: begin
                // Engine is idle here, so its CRC state is kept for as long as the source stalls.
                s_ready = 1'b1;
                if (s_valid) begin
                    shreg_d  = s_data;
                    last_d   = s_last;
                    bitcnt_d = 3'd0;
                    if (len_q != '1) begin
                        len_d = len_q + LEN_W'(1);
                    end
                    state_d = StShift;
                end
            end
            StFlush: begin
                // crc_in already holds the result of the eighth shift of the last byte.
                res_crc_d = crc_in ^ XorMask;
                state_d   = StDone;
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign res_crc = res_crc_q;
    assign res_len = len_q;

endmodule

// File: tb/tb_serial_crc_ccitt_ctrl.sv
// Directed bench for serial_crc_ccitt_ctrl with a behavioural CRC-CCITT (poly 0x1021) engine.
// A second instance with LEN_W=2 shares the stimulus to exercise byte-count saturation.
module tb_serial_crc_ccitt_ctrl;

`ifdef CRC_CTRL_XOROUT_EN
    localparam logic [15:0] XMASK = 16'hFFFF;
`else
    localparam logic [15:0] XMASK = 16'h0000;
`endif

    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        crc_init, crc_en, crc_m;
    logic [15:0] eng_crc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_crc;
    logic [15:0] res_len;

    logic        s_ready_s, crc_init_s, crc_en_s, crc_m_s, res_valid_s;
    logic [15:0] eng_crc_s, res_crc_s;
    logic [1:0]  res_len_s;

    logic [15:0] eng_init_value;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    int init_pulses = 0;
    int cyc      = 0;

    serial_crc_ccitt_ctrl #(.LEN_W(16), .XOROUT(16'hFFFF)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .crc_init(crc_init), .crc_en(crc_en), .crc_m(crc_m), .crc_in(eng_crc),
        .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_len(res_len)
    );

    serial_crc_ccitt_ctrl #(.LEN_W(2), .XOROUT(16'hFFFF)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data), .s_last(s_last),
        .crc_init(crc_init_s), .crc_en(crc_en_s), .crc_m(crc_m_s), .crc_in(eng_crc_s),
        .res_valid(res_valid_s), .res_ready(res_ready), .res_crc(res_crc_s),
        .res_len(res_len_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-serial CRC-CCITT engine models with registered output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) eng_crc <= 16'h0000;
        else if (crc_init) eng_crc <= eng_init_value;
        else if (crc_en) eng_crc <= {eng_crc[14:0], 1'b0} ^ ((eng_crc[15] ^ crc_m) ? 16'h1021 : 16'h0000);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) eng_crc_s <= 16'h0000;
        else if (crc_init_s) eng_crc_s <= eng_init_value;
        else if (crc_en_s) eng_crc_s <= {eng_crc_s[14:0], 1'b0} ^ ((eng_crc_s[15] ^ crc_m_s) ? 16'h1021 : 16'h0000);
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n) begin
            if (crc_init && crc_en) viol++;
            if (!crc_en && crc_m) viol++;
            if (crc_init) init_pulses++;
        end
    end

    // Drive one byte and hold it until accepted; returns on the negedge after the accept edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        ok = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (s_ready) ok = 1;
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout: byte %h not accepted within 200 cycles", d);
        end
    endtask

    task automatic wait_result(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (res_valid) ok = 1;
            else @(negedge clk);
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({res_valid, crc_init, crc_en, crc_m} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {res_valid, crc_init, crc_en, crc_m});
        else n_pass++;
        n_checks++;
        if (res_crc !== 16'h0000) $display("FAIL reset_crc: got %h expected 0000", res_crc);
        else n_pass++;
        n_checks++;
        if (res_len !== 16'd0) $display("FAIL reset_len: got %0d expected 0", res_len);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", s_ready);
        else n_pass++;
    endtask

    task automatic test_single_byte();
        logic [10:0] o_init, o_en, o_m, o_rv;
        eng_init_value = 16'h0000;
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", s_ready);
        else n_pass++;
        s_valid = 1'b1; s_data = 8'h41; s_last = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin s_valid = 1'b0; s_last = 1'b0; end
            o_init[k-1] = crc_init; o_en[k-1] = crc_en; o_m[k-1] = crc_m; o_rv[k-1] = res_valid;
        end
        n_checks++;
        if (o_init !== 11'h001) $display("FAIL single_init_seq: got %b expected %b", o_init, 11'h001);
        else n_pass++;
        n_checks++;
        if (o_en !== 11'h1FE) $display("FAIL single_en_seq: got %b expected %b", o_en, 11'h1FE);
        else n_pass++;
        n_checks++;
        if (o_m !== 11'h104) $display("FAIL single_m_seq: got %b expected %b", o_m, 11'h104);
        else n_pass++;
        n_checks++;
        if (o_rv !== 11'h400) $display("FAIL single_latency: got %b expected %b", o_rv, 11'h400);
        else n_pass++;
        n_checks++;
        if (res_crc !== (16'h58E5 ^ XMASK))
            $display("FAIL single_crc: got %h expected %h", res_crc, 16'h58E5 ^ XMASK);
        else n_pass++;
        n_checks++;
        if (res_len !== 16'd1) $display("FAIL single_len: got %0d expected 1", res_len);
        else n_pass++;
        release_result();
        n_checks++;
        if ({res_valid, s_ready} !== 2'b01)
            $display("FAIL single_release: got %b expected 01", {res_valid, s_ready});
        else n_pass++;
    endtask

    // With the XOR-out feature built in this is the 16'h46EA case.
    task automatic test_init_ffff();
        bit ok;
        eng_init_value = 16'hFFFF;
        send_byte(8'h41, 1'b1);
        wait_result(ok);
        n_checks++;
        if (!ok) $display("FAIL ffff_timeout: got no res_valid expected res_valid");
        else n_pass++;
        n_checks++;
        if (res_crc !== (16'hB915 ^ XMASK))
            $display("FAIL ffff_crc: got %h expected %h", res_crc, 16'hB915 ^ XMASK);
        else n_pass++;
        release_result();
    endtask

    task automatic test_back_to_back(input logic [15:0] init, input logic [15:0] exp_crc);
        bit ok;
        int p0, c0;
        eng_init_value = init;
        p0 = init_pulses;
        c0 = cyc;
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8);
        wait_result(ok);
        n_checks++;
        if (!ok) $display("FAIL b2b_timeout: got no res_valid expected res_valid");
        else n_pass++;
        n_checks++;
        if (cyc - c0 !== 83) $display("FAIL b2b_latency: got %0d expected 83", cyc - c0);
        else n_pass++;
        n_checks++;
        if (res_crc !== (exp_crc ^ XMASK))
            $display("FAIL b2b_crc: got %h expected %h", res_crc, exp_crc ^ XMASK);
        else n_pass++;
        n_checks++;
        if (res_len !== 16'd9) $display("FAIL b2b_len: got %0d expected 9", res_len);
        else n_pass++;
        n_checks++;
        if (init_pulses - p0 !== 1) $display("FAIL b2b_init_pulses: got %0d expected 1", init_pulses - p0);
        else n_pass++;
        n_checks++;
        if ({res_valid_s, res_len_s} !== 3'b111)
            $display("FAIL sat_len: got valid=%b len=%0d expected valid=1 len=3", res_valid_s, res_len_s);
        else n_pass++;
        n_checks++;
        if (res_crc_s !== (exp_crc ^ XMASK))
            $display("FAIL sat_crc: got %h expected %h", res_crc_s, exp_crc ^ XMASK);
        else n_pass++;
        release_result();
    endtask

    task automatic test_result_hold();
        bit ok;
        int p0, bad_data, bad_hs;
        eng_init_value = 16'h0000;
        send_byte(8'h41, 1'b1);
        wait_result(ok);
        bad_data = 0; bad_hs = 0;
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (res_crc !== (16'h58E5 ^ XMASK) || res_len !== 16'd1) bad_data++;
            if (res_valid !== 1'b1 || s_ready !== 1'b0) bad_hs++;
            @(negedge clk);
        end
        n_checks++;
        if (bad_data !== 0) $display("FAIL hold_data: got %0d unstable cycles expected 0", bad_data);
        else n_pass++;
        n_checks++;
        if (bad_hs !== 0) $display("FAIL hold_handshake: got %0d bad cycles expected 0", bad_hs);
        else n_pass++;
        p0 = init_pulses;
        release_result();
        n_checks++;
        if ({res_valid, s_ready} !== 2'b01)
            $display("FAIL hold_release: got %b expected 01", {res_valid, s_ready});
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        wait_result(ok);
        n_checks++;
        if (res_crc !== (16'h0A50 ^ XMASK))
            $display("FAIL hold_next_crc: got %h expected %h", res_crc, 16'h0A50 ^ XMASK);
        else n_pass++;
        n_checks++;
        if (init_pulses - p0 !== 1) $display("FAIL hold_next_init: got %0d expected 1", init_pulses - p0);
        else n_pass++;
        release_result();
    endtask

    task automatic test_wait_hold();
        bit ok;
        int en_cnt, rdy_bad;
        eng_init_value = 16'h0000;
        send_byte(8'h31, 1'b0);
        repeat (12) @(negedge clk);
        en_cnt = 0; rdy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (crc_en) en_cnt++;
            if (!s_ready) rdy_bad++;
            @(negedge clk);
        end
        n_checks++;
        if (en_cnt !== 0 || rdy_bad !== 0)
            $display("FAIL wait_idle: got en=%0d notready=%0d expected 0 0", en_cnt, rdy_bad);
        else n_pass++;
        for (int i = 1; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8);
        wait_result(ok);
        n_checks++;
        if (res_crc !== (16'h31C3 ^ XMASK) || res_len !== 16'd9)
            $display("FAIL wait_crc: got %h/%0d expected %h/9", res_crc, res_len, 16'h31C3 ^ XMASK);
        else n_pass++;
        release_result();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        eng_init_value = 16'h0000;
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (crc_en !== 1'b1) $display("FAIL mid_in_shift: got %b expected 1", crc_en);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({res_valid, crc_init, crc_en, crc_m} !== 4'b0000 || res_crc !== 16'h0000 ||
            res_len !== 16'd0)
            $display("FAIL mid_reset: got ctrl=%b crc=%h len=%0d expected 0000/0000/0",
                     {res_valid, crc_init, crc_en, crc_m}, res_crc, res_len);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({res_valid, s_ready} !== 2'b01)
            $display("FAIL mid_no_result: got %b expected 01", {res_valid, s_ready});
        else n_pass++;
        send_byte(8'h41, 1'b1);
        wait_result(ok);
        n_checks++;
        if (res_crc !== (16'h58E5 ^ XMASK) || res_len !== 16'd1)
            $display("FAIL mid_new_frame: got %h/%0d expected %h/1", res_crc, res_len, 16'h58E5 ^ XMASK);
        else n_pass++;
        release_result();
    endtask

    task automatic test_invariants();
        n_checks++;
        if (viol !== 0) $display("FAIL ctrl_invariants: got %0d violations expected 0", viol);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; res_ready = 1'b0;
        eng_init_value = 16'h0000;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_init_ffff();
        test_back_to_back(16'h0000, 16'h31C3);
        test_back_to_back(16'hFFFF, 16'h29B1);
        test_result_hold();
        test_wait_hold();
        test_reset_mid_frame();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
